// File: rtl/alu_sequencer.sv
// Sequences 2-bit register-file instructions through an external registered ALU.
// Latency: 3 edges from instruction handshake to the res_valid pulse.
// Backpressure: ready only in IDLE; preload outranks instructions; busy requests are ignored.
module alu_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [7:0]       instr,
    output logic             instr_ready,
    input  logic             ld_valid,
    input  logic [1:0]       ld_addr,
    input  logic [1:0]       ld_data,
    output logic             ld_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    input  logic [1:0]       alu_res,
    output logic             res_valid,
    output logic [1:0]       res_dst,
    output logic [1:0]       res_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    instr_t     ins;
    logic [1:0] regs [4];
    logic [1:0] rd_q;
    logic       instr_hs;
    logic       ld_hs;

    assign ins = instr;

    always_comb begin
        state_nxt   = state;
        ld_ready    = (state == IDLE);
        instr_ready = (state == IDLE) && !ld_valid;
        busy        = (state != IDLE);
        ld_hs       = ld_valid && ld_ready;
        instr_hs    = instr_valid && instr_ready;
        case (state)
            IDLE:    if (instr_hs) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operands are captured at the handshake and held until the next one,
    // so the ALU sees stable inputs through EXEC and WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            rd_q      <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_dst   <= '0;
            res_data  <= '0;
            done_cnt  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (ld_hs) regs[ld_addr] <= ld_data;
            if (instr_hs) begin
                alu_op <= ins.op;
                alu_a  <= regs[ins.ra];
                alu_b  <= regs[ins.rb];
                rd_q   <= ins.rd;
            end
            if (state == WB) begin
                regs[rd_q] <= alu_res;
                res_data   <= alu_res;
                res_dst    <= rd_q;
                res_valid  <= 1'b1;
                done_cnt   <= done_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against an instruction-level model.
module tb_alu_sequencer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic [7:0]       instr;
    logic             instr_ready;
    logic             ld_valid;
    logic [1:0]       ld_addr;
    logic [1:0]       ld_data;
    logic             ld_ready;
    logic [1:0]       alu_op;
    logic [1:0]       alu_a;
    logic [1:0]       alu_b;
    logic [1:0]       alu_res = 2'd0;
    logic             res_valid;
    logic [1:0]       res_dst;
    logic [1:0]       res_data;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int m_r [4];
    int m_cnt;
    int m_last_data;
    int m_last_dst;

    alu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .res_valid  (res_valid),
        .res_dst    (res_dst),
        .res_data   (res_data),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ref_alu(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = b + a;
            1:       r = b - a + 4;
            2:       r = a & b;
            default: r = 3 - a;
        endcase
        return r % 4;
    endfunction

    // Registered 2-bit ALU seen by the sequencer.
    always @(posedge clk) alu_res <= 2'(ref_alu(int'(alu_op), int'(alu_a), int'(alu_b)));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_cnt       = 0;
        m_last_data = 0;
        m_last_dst  = 0;
    endtask

    task automatic preload(input int addr, input int data);
        int n;
        ld_valid = 1'b1;
        ld_addr  = 2'(addr);
        ld_data  = 2'(data);
        n = 0;
        @(negedge clk);
        while (!ld_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ld_rdy_wait", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        m_r[addr] = data;
        check("ld_stays_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_instr(input int op, input int rd, input int ra, input int rb,
                             input bit hold_ld, input int h_addr, input int h_data,
                             output int got_data);
        int n;
        int exp_a;
        int exp_b;
        int exp_res;
        got_data    = -1;
        instr_valid = 1'b1;
        instr       = {2'(op), 2'(rd), 2'(ra), 2'(rb)};
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("instr_rdy_wait", 32'(instr_ready), 32'd1);
        if (!instr_ready) begin
            instr_valid = 1'b0;
            return;
        end
        exp_a   = m_r[ra];
        exp_b   = m_r[rb];
        exp_res = ref_alu(op, exp_a, exp_b);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (hold_ld) begin
            ld_valid = 1'b1;
            ld_addr  = 2'(h_addr);
            ld_data  = 2'(h_data);
        end
        check("exec_busy", 32'(busy), 32'd1);
        check("alu_op", 32'(alu_op), 32'(op));
        check("alu_a", 32'(alu_a), 32'(exp_a));
        check("alu_b", 32'(alu_b), 32'(exp_b));
        check("exec_res_valid", 32'(res_valid), 32'd0);
        check("res_data_hold", 32'(res_data), 32'(m_last_data));
        check("res_dst_hold", 32'(res_dst), 32'(m_last_dst));
        @(negedge clk);
        check("exec_ld_rdy", 32'(ld_ready), 32'd0);
        check("exec_instr_rdy", 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1;
        check("wb_busy", 32'(busy), 32'd1);
        check("wb_res_valid", 32'(res_valid), 32'd0);
        check("wb_alu_hold", 32'({alu_op, alu_a, alu_b}), 32'({2'(op), 2'(exp_a), 2'(exp_b)}));
        @(negedge clk);
        check("wb_ld_rdy", 32'(ld_ready), 32'd0);
        @(posedge clk);
        #1;
        m_r[rd]     = exp_res;
        m_cnt       = (m_cnt + 1) % (1 << CNT_W);
        m_last_data = exp_res;
        m_last_dst  = rd;
        check("ret_res_valid", 32'(res_valid), 32'd1);
        check("ret_res_dst", 32'(res_dst), 32'(rd));
        check("ret_res_data", 32'(res_data), 32'(exp_res));
        check("ret_done_cnt", 32'(done_cnt), 32'(m_cnt));
        check("ret_busy", 32'(busy), 32'd0);
        got_data = int'(res_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_outs", 32'({alu_op, alu_a, alu_b, res_dst, res_data}), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ld_rdy", 32'(ld_ready), 32'd1);
        check("post_rst_instr_rdy", 32'(instr_ready), 32'd1);

        // Add with carry discarded.
        preload(0, 1);
        preload(1, 3);
        run_instr(0, 2, 0, 1, 1'b0, 0, 0, got);
        check("add_wrap", 32'(got), 32'd0);

        // Subtract borrow, then AND.
        preload(0, 0);
        preload(1, 1);
        run_instr(1, 3, 1, 0, 1'b0, 0, 0, got);
        check("sub_borrow", 32'(got), 32'd3);
        run_instr(2, 0, 1, 1, 1'b0, 0, 0, got);
        check("and_op", 32'(got), 32'd1);

        // NOT overwrites its own source; the next read must see the new value.
        preload(1, 3);
        run_instr(3, 1, 1, 0, 1'b0, 0, 0, got);
        check("not_op", 32'(got), 32'd0);
        run_instr(0, 2, 1, 1, 1'b0, 0, 0, got);
        check("read_after_not", 32'(got), 32'd0);

        // Simultaneous preload and instruction: preload wins this cycle.
        ld_valid    = 1'b1;
        ld_addr     = 2'd3;
        ld_data     = 2'd2;
        instr_valid = 1'b1;
        instr       = 8'b00_00_11_11;
        @(negedge clk);
        check("prio_instr_rdy", 32'(instr_ready), 32'd0);
        check("prio_ld_rdy", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        m_r[3] = 2;
        run_instr(0, 0, 3, 3, 1'b0, 0, 0, got);
        check("prio_result", 32'(got), 32'd0);

        // Preload held while busy is taken only once IDLE returns.
        run_instr(0, 2, 3, 3, 1'b1, 2, 1, got);
        @(negedge clk);
        check("held_ld_rdy", 32'(ld_ready), 32'd1);
        check("held_instr_rdy", 32'(instr_ready), 32'd0);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        m_r[2] = 1;
        check("held_ld_idle", 32'(busy), 32'd0);
        run_instr(0, 0, 2, 2, 1'b0, 0, 0, got);
        check("held_ld_value", 32'(got), 32'd2);

        // Reset in WB discards the in-flight instruction.
        preload(0, 1);
        preload(1, 2);
        preload(2, 3);
        preload(3, 1);
        instr_valid = 1'b1;
        instr       = 8'b00_00_01_10;
        @(negedge clk);
        check("abort_instr_rdy", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_wb", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_outs", 32'({alu_op, alu_a, alu_b, res_dst, res_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("abort_no_pulse", 32'(res_valid), 32'd0);

        // Back-to-back retirements wrap the 2-bit counter; registers read back as zero.
        run_instr(0, 0, 0, 1, 1'b0, 0, 0, got);
        run_instr(0, 1, 2, 3, 1'b0, 0, 0, got);
        run_instr(3, 2, 0, 0, 1'b0, 0, 0, got);
        run_instr(1, 3, 2, 1, 1'b0, 0, 0, got);
        run_instr(2, 0, 2, 3, 1'b0, 0, 0, got);
        check("wrap_done_cnt", 32'(done_cnt), 32'd1);

        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = int'($urandom_range(0, 4));
            if (sel == 0) begin
                preload(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else if (sel == 1) begin
                int ha;
                int hd;
                ha = int'($urandom_range(0, 3));
                hd = int'($urandom_range(0, 3));
                run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'b1, ha, hd, got);
                @(negedge clk);
                check("rnd_held_ld_rdy", 32'(ld_ready), 32'd1);
                @(posedge clk);
                #1;
                ld_valid = 1'b0;
                m_r[ha] = hd;
            end else begin
                run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          1'b0, 0, 0, got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: CNT_W, 8, width of the completed-instruction counter.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr  in  8  {op[7:6], rd[5:4], ra[3:2], rb[1:0]}.
REQ-007 instr_ready  out  1  instruction accepted when instr_valid && instr_ready at a clk edge.
REQ-008 ld_valid  in  1  register preload request.
REQ-009 ld_addr  in  2  preload target register.
REQ-010 ld_data  in  2  preload value.
REQ-011 ld_ready  out  1  preload accepted when ld_valid && ld_ready at a clk edge.
REQ-012 alu_op  out  2  operation to the registered 2-bit ALU: 0 add B+A, 1 sub B-A, 2 and, 3 not A.
REQ-013 alu_a  out  2  ALU operand A (R[ra]).
REQ-014 alu_b  out  2  ALU operand B (R[rb]).
REQ-015 alu_res  in  2  ALU registered result, one-cycle latency.
REQ-016 res_valid  out  1  one-cycle pulse: instruction retired.
REQ-017 res_dst  out  2  destination register of the retired instruction.
REQ-018 res_data  out  2  value written to res_dst.
REQ-019 busy  out  1  high whenever state is not IDLE.
REQ-020 done_cnt  out  CNT_W  number of retired instructions, modulo 2^CNT_W.

Function
REQ-021 Register file R0..R3 is 2 bits per entry, held internally.
REQ-022 FSM states: IDLE, EXEC, WB; transitions IDLE->EXEC on instruction handshake, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-023 ld_ready = (state==IDLE); instr_ready = (state==IDLE) && !ld_valid (preload has priority).
REQ-024 Preload handshake: R[ld_addr] <= ld_data at that edge; state stays IDLE.
REQ-025 Instruction handshake edge (T0): alu_op, alu_a, alu_b registered from op, R[ra], R[rb]; rd latched internally.
REQ-026 alu_op/alu_a/alu_b hold stable through EXEC and WB; the ALU samples them at edge T1.
REQ-027 In WB, alu_res is valid; at edge T2: R[rd] <= alu_res, res_data <= alu_res, res_dst <= rd, res_valid <= 1, done_cnt increments.
REQ-028 res_valid is high for exactly the one cycle after T2, which is also the first IDLE cycle; res_data/res_dst hold until the next retirement.
REQ-029 Latency: handshake to res_valid = 3 edges; maximum throughput is one instruction per 3 cycles.
REQ-030 Operand reads at T0 see any write performed at an earlier edge, including a retirement at the preceding edge; no hazard logic is needed.
REQ-031 Arithmetic is mod 4 (carry/borrow discarded); the controller never alters alu_res.
REQ-032 ld_valid and instr_valid while busy are ignored and not stored; the requester must hold them.
REQ-033 done_cnt wraps from 2^CNT_W-1 to 0 without flag.
REQ-034 rd equal to ra or rb is legal; operands are the pre-write values.

Reset
REQ-035 rst_n low asynchronously forces: state IDLE, R0..R3 = 0, alu_op/alu_a/alu_b = 0, res_valid = 0, res_dst = 0, res_data = 0, done_cnt = 0.
REQ-036 Reset during EXEC or WB discards the in-flight instruction: no register write, no res_valid pulse, no count.
REQ-037 After rst_n deasserts, ld_ready and instr_ready are high from the first clk edge onward (instr_ready subject to REQ-023).

Verification
REQ-038 Preload R0=1, R1=3; instr op=0 rd=2 ra=0 rb=1 -> res_valid 3 edges after the handshake, res_dst=2, res_data=0 (3+1 mod 4), R2=0.
REQ-039 R0=0, R1=1; op=1 rd=3 ra=1 rb=0 -> res_data=3 (0-1 borrow wraps); op=2 rd=0 ra=1 rb=1 -> res_data=1.
REQ-040 R1=3; op=3 rd=1 ra=1 rb=x -> res_data=0 and R1=0; the next instruction reading R1 sees 0.
REQ-041 ld_valid and instr_valid both high in IDLE -> preload taken, instr_ready=0 that cycle, instruction accepted next cycle; requests held during busy are accepted only in IDLE.
REQ-042 Assert rst_n low during WB -> no res_valid, done_cnt unchanged at 0, all registers 0.
REQ-043 With CNT_W=2, retire 5 instructions back-to-back -> done_cnt sequence 1,2,3,0,1; busy pattern 1,1,0 repeating.
